// File: rtl/nois_system_nios2_qsys_0_oci_dct_monitor.sv
// Data-trace monitor: captures {dct_count, dct_buffer} into a FIFO whenever
// the trace fragment count changes, drains it over a valid/ready port, and
// reports completion once the test has ended and the FIFO is empty.
module nois_system_nios2_qsys_0_oci_dct_monitor #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         dct_buffer,
  input  logic [CNT_W-1:0]          dct_count,
  input  logic                      test_ending,
  input  logic                      test_has_ended,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic [CNT_W+DATA_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic                      overflow,
  output logic [DROP_W-1:0]         drop_count,
  output logic [31:0]               capture_count,
  output logic                      done
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = CNT_W + DATA_W;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  prev_count;
  logic              ended;
  logic              change, full, pop, push, drop;

  assign change   = (dct_count != prev_count);
  assign full     = (fill_level == FULL_LVL);
  assign rd_valid = (fill_level != '0);
  assign pop      = rd_valid && rd_ready;
  assign done     = (state == DONE);
  // Gate the head so the port reads 0 while empty (memory has no reset).
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // Next state and capture decision; an end request preempts a same-cycle change.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    drop      = 1'b0;
    case (state)
      RUN: begin
        if (test_ending || test_has_ended) begin
          state_nxt = DRAIN;
        end else if (change) begin
          if (!full || pop) push = 1'b1;
          else              drop = 1'b1;
        end
      end
      DRAIN: begin
        if ((ended || test_has_ended) && fill_level == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  // State register, ended latch and count history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      ended      <= 1'b0;
      prev_count <= '0;
    end else begin
      state      <= state_nxt;
      prev_count <= dct_count;
      if (test_has_ended && state != DONE) ended <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; a full-FIFO push pairs with a pop so level holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase
    end
  end

  // Entry storage; write slot may equal the head being popped this cycle.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {dct_count, dct_buffer};
  end

  // Statistics: accepted entries wrap, drops saturate, overflow is sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      capture_count <= '0;
      drop_count    <= '0;
      overflow      <= 1'b0;
    end else begin
      if (push) capture_count <= capture_count + 32'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nois_system_nios2_qsys_0_oci_dct_monitor.sv
// Directed bench for the data-trace monitor: reset, capture, overflow,
// full-with-pop, end-of-test drain and asynchronous reset during drain.
module tb_nois_system_nios2_qsys_0_oci_dct_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending, test_has_ended, rd_ready;
  logic        rd_valid;
  logic [33:0] rd_data;
  logic [4:0]  fill_level;
  logic        overflow;
  logic [15:0] drop_count;
  logic [31:0] capture_count;
  logic        done;

  int checks = 0;
  int errors = 0;

  nois_system_nios2_qsys_0_oci_dct_monitor dut (
    .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .fill_level(fill_level),
    .overflow(overflow), .drop_count(drop_count), .capture_count(capture_count),
    .done(done)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dct_count = '0; dct_buffer = '0;
    test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (10) step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b exp 0", rd_valid); end
    checks++; if (rd_data !== 34'h0) begin errors++; $display("FAIL reset_rd_data: got %h exp 0", rd_data); end
    checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL reset_fill: got %0d exp 0", fill_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d exp 0", drop_count); end
    checks++; if (capture_count !== 32'd0) begin errors++; $display("FAIL reset_capture: got %0d exp 0", capture_count); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
  endtask

  task automatic test_single_capture();
    logic [33:0] exp;
    exp = {4'h3, 30'h12345678};
    dct_buffer = 30'h12345678; dct_count = 4'h3;
    step();
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", rd_valid); end
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL single_data: got %h exp %h", rd_data, exp); end
    checks++; if (fill_level !== 5'd1) begin errors++; $display("FAIL single_fill: got %0d exp 1", fill_level); end
    checks++; if (capture_count !== 32'd1) begin errors++; $display("FAIL single_capture: got %0d exp 1", capture_count); end
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b exp 0", rd_valid); end
  endtask

  task automatic test_overflow();
    logic [33:0] exp;
    logic [3:0]  c;
    logic [29:0] b;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      c = 4'(i); b = 30'(100 + i);
      dct_count = c; dct_buffer = b;
      step();
    end
    checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL ovf_fill: got %0d exp 16", fill_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b exp 1", overflow); end
    checks++; if (drop_count !== 16'd4) begin errors++; $display("FAIL ovf_drop: got %0d exp 4", drop_count); end
    checks++; if (capture_count !== 32'd16) begin errors++; $display("FAIL ovf_capture: got %0d exp 16", capture_count); end
    rd_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      c = 4'(i); b = 30'(100 + i); exp = {c, b};
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL ovf_drain_%0d: got %h exp %h", i, rd_data, exp); end
      step();
    end
    rd_ready = 1'b0;
    checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL ovf_drained: got %0d exp 0", fill_level); end
  endtask

  task automatic test_full_pop();
    logic [33:0] exp;
    logic [3:0]  c;
    logic [29:0] b;
    // count is 4 from the previous task
    for (int k = 1; k <= 16; k++) begin
      c = 4'(4 + k); b = 30'(200 + k);
      dct_count = c; dct_buffer = b;
      step();
    end
    checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL fp_prefill: got %0d exp 16", fill_level); end
    dct_count = 4'd9; dct_buffer = 30'd999; rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL fp_fill: got %0d exp 16", fill_level); end
    checks++; if (drop_count !== 16'd4) begin errors++; $display("FAIL fp_drop: got %0d exp 4", drop_count); end
    checks++; if (capture_count !== 32'd33) begin errors++; $display("FAIL fp_capture: got %0d exp 33", capture_count); end
    rd_ready = 1'b1;
    for (int k = 2; k <= 17; k++) begin
      if (k == 17) begin c = 4'd9; b = 30'd999; end
      else begin c = 4'(4 + k); b = 30'(200 + k); end
      exp = {c, b};
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL fp_drain_%0d: got %h exp %h", k, rd_data, exp); end
      step();
    end
    rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL fp_empty: got %b exp 0", rd_valid); end
  endtask

  task automatic test_end_of_test();
    logic [33:0] exp;
    logic [3:0]  c;
    logic [29:0] b;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      c = 4'(i); b = 30'(i * 17);
      dct_count = c; dct_buffer = b;
      step();
    end
    test_ending = 1'b1; dct_count = 4'd4; dct_buffer = 30'h3ff;
    step();
    test_ending = 1'b0; test_has_ended = 1'b1;
    step();
    test_has_ended = 1'b0;
    checks++; if (fill_level !== 5'd3) begin errors++; $display("FAIL end_fill: got %0d exp 3", fill_level); end
    checks++; if (capture_count !== 32'd3) begin errors++; $display("FAIL end_capture: got %0d exp 3", capture_count); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL end_done_early: got %b exp 0", done); end
    rd_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      c = 4'(i); b = 30'(i * 17); exp = {c, b};
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL end_drain_%0d: got %h exp %h", i, rd_data, exp); end
      step();
    end
    rd_ready = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL end_done_at_pop: got %b exp 0", done); end
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL end_done: got %b exp 1", done); end
    dct_count = 4'd11;
    step();
    checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL end_no_capture: got %0d exp 0", fill_level); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL end_done_hold: got %b exp 1", done); end
  endtask

  task automatic test_reset_mid_drain();
    logic [33:0] exp;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      dct_count = 4'(i); dct_buffer = 30'(i);
      step();
    end
    test_ending = 1'b1;
    step();
    test_ending = 1'b0;
    step();
    checks++; if (fill_level !== 5'd5) begin errors++; $display("FAIL mid_fill: got %0d exp 5", fill_level); end
    #2;
    reset = 1'b1; dct_count = 4'd0;
    #1;
    checks++; if (rd_valid !== 1'b0 || fill_level !== 5'd0 || rd_data !== 34'h0)
      begin errors++; $display("FAIL mid_async_fifo: valid %b fill %0d data %h exp 0", rd_valid, fill_level, rd_data); end
    checks++; if (overflow !== 1'b0 || drop_count !== 16'd0 || capture_count !== 32'd0 || done !== 1'b0)
      begin errors++; $display("FAIL mid_async_stats: ovf %b drop %0d cap %0d done %b exp 0", overflow, drop_count, capture_count, done); end
    step();
    reset = 1'b0;
    step();
    dct_count = 4'd7; dct_buffer = 30'h77;
    step();
    exp = {4'd7, 30'h77};
    checks++; if (rd_valid !== 1'b1 || fill_level !== 5'd1) begin errors++; $display("FAIL mid_recapture: valid %b fill %0d exp 1 1", rd_valid, fill_level); end
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL mid_recapture_data: got %h exp %h", rd_data, exp); end
    checks++; if (capture_count !== 32'd1) begin errors++; $display("FAIL mid_recapture_cnt: got %0d exp 1", capture_count); end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single_capture();
    test_overflow();
    test_full_pop();
    test_end_of_test();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1);
  end

endmodule

// File: doc/nois_system_nios2_qsys_0_oci_dct_monitor.md
# nois_system_nios2_qsys_0_oci_dct_monitor

Synthesizable, parametrised successor to the OCI test-bench stub for the Nios II data-trace path. It watches the trace buffer (`dct_buffer`) and its fragment counter (`dct_count`), and captures a tagged entry into an internal FIFO on every counter change. It drains captured entries over a valid/ready port and reports end-of-test completion. It sits beside the OCI trace logic in `nois_system_nios2_qsys_0` and feeds a debug reader or a simulation checker.

## Interface
- `DATA_W`, 30: width of `dct_buffer`.
- `CNT_W`, 4: width of `dct_count`.
- `DEPTH`, 16: number of FIFO entries; a power of two, ≥2.
- `DROP_W`, 16: width of the drop counter.

Ports:
- `clk`  in  1: single clock; every flop is on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `dct_buffer`  in  DATA_W: trace buffer contents.
- `dct_count`  in  CNT_W: trace fragment count.
- `test_ending`  in  1: end of test requested.
- `test_has_ended`  in  1: test finished.
- `rd_ready`  in  1: consumer accepts the head entry.
- `rd_valid`  out  1: head entry is available.
- `rd_data`  out  CNT_W+DATA_W: head entry, `{dct_count, dct_buffer}`.
- `fill_level`  out  clog2(DEPTH)+1: number of entries held.
- `overflow`  out  1: sticky flag, set when an entry was dropped.
- `drop_count`  out  DROP_W: dropped entries, saturating.
- `capture_count`  out  32: accepted entries, wraps modulo 2^32.
- `done`  out  1: test ended and FIFO drained.

## Operation
- `prev_count` is a register holding the last sampled `dct_count`. Reset value is 0.
- Change event: `dct_count != prev_count`. `prev_count` updates every cycle, in all states.
- State machine states: RUN (reset state), DRAIN, DONE.
- RUN, on a change event:
  - FIFO not full, or full with a pop in the same cycle: write `{dct_count, dct_buffer}` and increment `capture_count`.
  - FIFO full with no pop: drop the entry, set `overflow`, and increment `drop_count`, saturating at all-ones.
- RUN → DRAIN when `test_ending` or `test_has_ended` is sampled high. A change event in that same cycle is not captured.
- DRAIN: no captures. Popping continues. A latched `ended` flag is set when `test_has_ended` is sampled high.
- DRAIN → DONE when `ended` is set, or `test_has_ended` is high that cycle, and `fill_level == 0`.
- DONE: `done` = 1 until reset. The inputs are ignored.
- Pop: occurs when `rd_valid && rd_ready`. It removes the head entry. Allowed in every state.
- `rd_valid` = (`fill_level != 0`). `rd_data` = head entry; its value is don't-care when empty.
- Reset, asynchronous at any time: empties the FIFO and sets state = RUN. All outputs go to 0.

## Timing
- Reset values: `rd_valid` = 0, `rd_data` = 0, `fill_level` = 0, `overflow` = 0, `drop_count` = 0, `capture_count` = 0, `done` = 0.
- Capture latency: a change sampled at edge N gives `rd_valid` = 1 and the entry on `rd_data` after edge N. This applies when the FIFO was empty.
- Pop takes effect at the edge where `rd_valid && rd_ready`. The next entry appears after that edge, or `rd_valid` falls.
- Simultaneous push and pop at `fill_level == DEPTH`: both succeed and `fill_level` is unchanged. No overflow.
- Simultaneous push and pop at `fill_level == 0`: the push is stored and the pop is a no-op (`rd_valid` was 0).
- Pointers wrap modulo DEPTH. `fill_level` ranges 0..DEPTH.
- `done` rises at the edge after the cycle in which the last entry is popped with `ended` set. If `ended` is set with the FIFO already empty, `done` rises at the next edge.
- `rd_ready` never stalls capture. Only a full FIFO causes drops.

## Test plan
- Reset then idle: hold `dct_count` = 0 for 10 cycles → all outputs 0, `rd_valid` = 0.
- Single capture: `dct_buffer` = 0x12345678 with `dct_count` 0→3, `rd_ready` = 0 → one cycle later `rd_valid` = 1, `rd_data` = {4'h3, 30'h12345678}, `fill_level` = 1, `capture_count` = 1.
- Overflow: 20 distinct count changes with DEPTH = 16 and `rd_ready` = 0 → `fill_level` = 16, `overflow` = 1, `drop_count` = 4, `capture_count` = 16. Draining then returns the first 16 entries in order.
- Full with concurrent pop: at `fill_level` 16, change `dct_count` while `rd_ready` = 1 → `fill_level` stays 16, `drop_count` unchanged, new entry at the tail.
- End of test: 3 entries queued, pulse `test_ending`, then `test_has_ended`, plus a count change in the `test_ending` cycle → the change is not captured. Pop 3 entries and `done` = 1 one edge after the last pop.
- Reset mid-drain: in DRAIN with 5 entries, assert `reset` asynchronously → all outputs 0 immediately. After release, state is RUN and a new change is captured.
